pipe_ctrl: RTL



---
 rtl/y86_pkg.sv | 38 +++
 rtl/pipe_ctrl_sat_counter.sv | 19 +
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, register IDs, status codes and
// the hazard controller FSM state.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } ctrl_state_t;

  // Undefined status encodings are recorded as an invalid instruction.
  function automatic logic [2:0] sanitize_stat(input logic [2:0] s);
    case (s)
      SADR, SINS, SHLT: sanitize_stat = s;
      default:          sanitize_stat = SINS;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard event statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/bubble controller for the five-stage Y86-64 pipeline, with a sticky
// halt state machine and saturating hazard event counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             F_bubble,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             cc_en,
  output logic             halted,
  output logic [2:0]       halt_stat,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  ctrl_state_t state_q, state_d;
  logic [2:0]  halt_stat_q;
  logic        load_use, ret_in_pipe, mispred, exc_m, exc_w;
  logic        run, d_stall_raw, d_bubble_raw;

  assign load_use    = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                       (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_in_pipe = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mispred     = (E_icode == IJXX) && !e_Cnd;
  assign exc_m       = (m_stat != SAOK);
  assign exc_w       = (W_stat != SAOK);

  assign run = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      halt_stat_q <= SAOK;
    end else begin
      state_q <= state_d;
      if (run && exc_w) begin
        halt_stat_q <= sanitize_stat(W_stat);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (run && exc_w) begin
      state_d = ST_HALTED;
    end
  end

  // D_stall takes priority should both D controls ever assert together.
  assign d_stall_raw  = load_use;
  assign d_bubble_raw = mispred || (ret_in_pipe && !load_use);

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    F_bubble = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    cc_en    = 1'b0;
    if (!rst_n) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (!run) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else begin
      F_stall  = load_use || ret_in_pipe;
      D_stall  = d_stall_raw;
      D_bubble = d_bubble_raw && !d_stall_raw;
      E_bubble = mispred || load_use;
      M_bubble = exc_m || exc_w;
      W_stall  = exc_w;
      cc_en    = (E_icode == IOPQ) && !exc_m && !exc_w;
    end
  end

  assign halted    = rst_n && !run;
  assign halt_stat = rst_n ? halt_stat_q : SAOK;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run && load_use),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run && ret_in_pipe && !load_use),
    .q     (ret_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run && mispred),
    .q     (mispred_cnt)
  );

endmodule
